// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, state geometry, byte slicing and GF(2^8) helpers
// used by the S-box and the serial SubBytes stage.
package aes_pkg;

    localparam int unsigned AES_BYTES = 16;
    localparam int unsigned AES_BITS  = AES_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sb_state_t;

    // MSB position of byte k in a state laid out as byte k = state[127-8k -: 8]
    function automatic logic [6:0] byte_msb(input int unsigned k);
        return 7'(AES_BITS - 1 - 8 * k);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as AES requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    endfunction

endpackage

// File: rtl/sbox_inv_lut.sv
// Merged forward/inverse AES S-box; both directions share one GF(2^8) inverter.
module sbox_inv_lut
    import aes_pkg::*;
(
    input  logic       encrypt,
    input  logic [7:0] byte_val,
    output logic [7:0] sub_c
);

    logic [7:0] inv_src;
    logic [7:0] inv_res;

    // Forward: affine(inv(x)); inverse: inv(inv_affine(x))
    always_comb begin
        inv_src = encrypt ? byte_val : inv_affine(byte_val);
        inv_res = gf_inv(inv_src);
        sub_c   = encrypt ? affine(inv_res) : inv_res;
    end

endmodule

// File: rtl/subbytes_serial.sv
// Sequential SubBytes stage: streams a 128-bit state through NUM_SBOX S-boxes per cycle
// and presents the collected result on a valid/ready handshake.
module subbytes_serial
    import aes_pkg::*;
#(
    parameter int unsigned NUM_SBOX = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                encrypt,
    input  logic [AES_BITS-1:0] state_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [AES_BITS-1:0] state_out,
    output logic                busy
);

    localparam int unsigned GROUPS = AES_BYTES / NUM_SBOX;
    localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    sb_state_t           state_q;
    sb_state_t           state_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic [AES_BITS-1:0] src_q;
    logic [AES_BITS-1:0] src_d;
    logic                enc_q;
    logic                enc_d;
    logic [AES_BITS-1:0] result_d;
    logic                in_ready_d;
    logic                out_valid_d;
    logic                busy_d;
    int unsigned         lane_base;

    logic [7:0] sbox_in  [NUM_SBOX];
    logic [7:0] sbox_out [NUM_SBOX];

    assign lane_base = 32'(count_q) * NUM_SBOX;

    // Select the current group of source bytes
    always_comb begin
        for (int unsigned i = 0; i < NUM_SBOX; i++) begin
            sbox_in[i] = src_q[byte_msb(lane_base + i) -: 8];
        end
    end

    for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
        sbox_inv_lut u_sbox (
            .encrypt  (enc_q),
            .byte_val (sbox_in[g]),
            .sub_c    (sbox_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            src_q     <= '0;
            enc_q     <= 1'b1;
            state_out <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            src_q     <= src_d;
            enc_q     <= enc_d;
            state_out <= result_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        src_d    = src_q;
        enc_d    = enc_q;
        result_d = state_out;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    src_d   = state_in;
                    enc_d   = encrypt;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NUM_SBOX; i++) begin
                    result_d[byte_msb(lane_base + i) -: 8] = sbox_out[i];
                end
                if (count_q == CNT_W'(GROUPS - 1)) begin
                    count_d = '0;
                    state_d = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

endmodule

// File: tb/tb_subbytes_serial.sv
// Self-checking bench for subbytes_serial: table-based S-box reference, randomized blocks,
// latency, backpressure, mid-run reset and back-to-back scenarios.
module tb_subbytes_serial;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, encrypt = 1'b1, out_ready = 1'b1;
    logic [127:0] state_in = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] state_out;
    logic         in_valid_p = 1'b0, encrypt_p = 1'b1, out_ready_p = 1'b1;
    logic [127:0] state_in_p = '0;
    logic         in_ready4, out_valid4, busy4, in_ready16, out_valid16, busy16;
    logic [127:0] state_out4, state_out16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    subbytes_serial #(.NUM_SBOX(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .encrypt(encrypt),
        .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
        .state_out(state_out), .busy(busy));

    subbytes_serial #(.NUM_SBOX(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_p), .in_ready(in_ready4), .encrypt(encrypt_p),
        .state_in(state_in_p), .out_valid(out_valid4), .out_ready(out_ready_p),
        .state_out(state_out4), .busy(busy4));

    subbytes_serial #(.NUM_SBOX(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_p), .in_ready(in_ready16), .encrypt(encrypt_p),
        .state_in(state_in_p), .out_valid(out_valid16), .out_ready(out_ready_p),
        .state_out(state_out16), .busy(busy16));

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int v = 0; v < 256; v++) if (SBOX[v] == b) r = 8'(v);
        return r;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] st, input logic enc);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = st[127-8*k -: 8];
            r[127-8*k -: 8] = enc ? SBOX[b] : inv_sbox(b);
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake one block into dut, optionally scrambling inputs during RUN; returns latency
    task automatic run_block(input logic [127:0] data, input logic enc, input bit scramble,
                             output int lat);
        state_in = data;
        encrypt  = enc;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (scramble) begin
                state_in = rand128();
                encrypt  = 1'($urandom);
            end
            tick();
            lat++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout got %b exp 1", out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || state_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_dut1 got rdy/vld/busy %b out %h exp 100 0", {in_ready, out_valid, busy}, state_out);
        end
        checks++;
        if ({in_ready4, out_valid4, busy4, in_ready16, out_valid16, busy16} !== 6'b100100
            || state_out4 !== 128'h0 || state_out16 !== 128'h0) begin
            errors++;
            $display("FAIL reset_par got %b exp 100100", {in_ready4, out_valid4, busy4, in_ready16, out_valid16, busy16});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fips();
        int lat;
        out_ready = 1'b1;
        run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b1, 1'b0, lat);
        checks++;
        if (lat != 16) begin
            errors++;
            $display("FAIL fips_latency got %0d exp 16", lat);
        end
        checks++;
        if (state_out !== 128'hd42711aee0bf98f1b8b45de51e415230) begin
            errors++;
            $display("FAIL fips_fwd got %h exp d42711aee0bf98f1b8b45de51e415230", state_out);
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fips_done_flags got busy %b rdy %b exp 1 0", busy, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fips_release got vld %b rdy %b busy %b exp 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_inverse();
        int lat;
        run_block(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b0, lat);
        checks++;
        if (state_out !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin
            errors++;
            $display("FAIL inv_fips got %h exp 193de3bea0f4e22b9ac68d2ae9f84808", state_out);
        end
        tick();
        run_block(128'h0, 1'b0, 1'b0, lat);
        checks++;
        if (state_out !== {16{8'h52}}) begin
            errors++;
            $display("FAIL inv_zero got %h exp %h", state_out, {16{8'h52}});
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] d;
        logic e;
        for (int n = 0; n < 8; n++) begin
            d = rand128();
            e = 1'($urandom);
            run_block(d, e, 1'b0, lat);
            checks++;
            if (state_out !== ref_sub(d, e)) begin
                errors++;
                $display("FAIL random_%0d enc %b got %h exp %h", n, e, state_out, ref_sub(d, e));
            end
            tick();
        end
    endtask

    task automatic test_parallel(input logic [127:0] d, input logic e);
        int l4;
        int l16;
        logic [127:0] r4;
        logic [127:0] r16;
        l4 = -1; l16 = -1; r4 = '0; r16 = '0;
        out_ready_p = 1'b0;
        state_in_p  = d;
        encrypt_p   = e;
        in_valid_p  = 1'b1;
        checks++;
        if (in_ready4 !== 1'b1 || in_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL par_ready got %b%b exp 11", in_ready4, in_ready16);
        end
        tick();
        in_valid_p = 1'b0;
        for (int c = 1; c <= 30 && (l4 < 0 || l16 < 0); c++) begin
            tick();
            if (out_valid4 === 1'b1 && l4 < 0) begin l4 = c; r4 = state_out4; end
            if (out_valid16 === 1'b1 && l16 < 0) begin l16 = c; r16 = state_out16; end
        end
        checks++;
        if (l4 != 4 || l16 != 1) begin
            errors++;
            $display("FAIL par_latency got %0d/%0d exp 4/1", l4, l16);
        end
        checks++;
        if (r4 !== ref_sub(d, e) || r16 !== ref_sub(d, e)) begin
            errors++;
            $display("FAIL par_data got %h / %h exp %h", r4, r16, ref_sub(d, e));
        end
        out_ready_p = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] d;
        logic [127:0] held;
        d = rand128();
        out_ready = 1'b0;
        run_block(d, 1'b1, 1'b0, lat);
        held = state_out;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            state_in = rand128();
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || state_out !== held || held !== ref_sub(d, 1'b1)) begin
                errors++;
                $display("FAIL bp_hold_%0d got vld %b rdy %b out %h exp 1 0 %h", c, out_valid, in_ready, state_out, ref_sub(d, 1'b1));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        d = rand128();
        run_block(d, 1'b0, 1'b1, lat);
        checks++;
        if (state_out !== ref_sub(d, 1'b0)) begin
            errors++;
            $display("FAIL bp_scramble got %h exp %h", state_out, ref_sub(d, 1'b0));
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [127:0] d;
        state_in = rand128();
        encrypt  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (state_out !== 128'h0 || {out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL midrun_reset got out %h vld/rdy/busy %b exp 0 010", state_out, {out_valid, in_ready, busy});
        end
        d = rand128();
        run_block(d, 1'b0, 1'b0, lat);
        checks++;
        if (state_out !== ref_sub(d, 1'b0) || lat != 16) begin
            errors++;
            $display("FAIL after_reset got %h lat %0d exp %h 16", state_out, lat, ref_sub(d, 1'b0));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk [2];
        logic [127:0] outs [2];
        int acc_cyc [2];
        int nacc;
        int nout;
        bit acc;
        blk[0] = 128'h0;
        blk[1] = {16{8'h53}};
        outs[0] = '0; outs[1] = '0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        nacc = 0; nout = 0;
        out_ready = 1'b1;
        encrypt   = 1'b1;
        state_in  = blk[0];
        in_valid  = 1'b1;
        for (int c = 0; c < 80 && nout < 2; c++) begin
            acc = (in_ready === 1'b1) && in_valid;
            if (acc && nacc < 2) acc_cyc[nacc] = c;
            tick();
            if (acc) begin
                nacc++;
                if (nacc < 2) state_in = blk[nacc];
                else in_valid = 1'b0;
            end
            if (out_valid === 1'b1 && nout < 2) begin
                outs[nout] = state_out;
                nout++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nout != 2 || outs[0] !== {16{8'h63}} || outs[1] !== {16{8'hed}}) begin
            errors++;
            $display("FAIL b2b_data got %0d outs %h %h exp 2 %h %h", nout, outs[0], outs[1], {16{8'h63}}, {16{8'hed}});
        end
        checks++;
        if (nacc != 2 || acc_cyc[1] - acc_cyc[0] != 18) begin
            errors++;
            $display("FAIL b2b_period got accepts %0d gap %0d exp 2 18", nacc, acc_cyc[1] - acc_cyc[0]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_fips();
        test_inverse();
        test_random();
        test_parallel(128'h0, 1'b1);
        test_parallel(rand128(), 1'b0);
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
